// File: rtl/pong_engine.sv
// pong_engine: paddle/ball/score state, PS/2 held-key tracking, pixel colour.
// Define PONG_AI_EN to let the right paddle chase the ball instead of keys.
module pong_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_X    = 16,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SPEED  = 2,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60,
  parameter logic [7:0] KEY_P1_UP = 8'h1D,
  parameter logic [7:0] KEY_P1_DN = 8'h1B,
  parameter logic [7:0] KEY_P2_UP = 8'h75,
  parameter logic [7:0] KEY_P2_DN = 8'h72,
  parameter logic [7:0] KEY_SERVE = 8'h29
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        done,
  input  logic [7:0]  tasta,
  input  logic        active_zone,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  output logic [11:0] color,
  output logic [3:0]  score_player_1,
  output logic [3:0]  score_player_2,
  output logic        game_over,
  output logic        winner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [9:0]  PY0    = 10'(V_RES / 2 - PADDLE_H / 2);
  localparam logic [9:0]  BX0    = 10'(H_RES / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  BY0    = 10'(V_RES / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  PY_MAX = 10'(V_RES - PADDLE_H);
  localparam logic [9:0]  BY_MAX = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0]  STEP   = 10'(PADDLE_STEP);
  localparam logic [9:0]  SPD    = 10'(BALL_SPEED);
  localparam logic [9:0]  L_OUT  = 10'(PADDLE_X);
  localparam logic [9:0]  L_IN   = 10'(PADDLE_X + PADDLE_W);
  localparam logic [9:0]  R_IN   = 10'(H_RES - PADDLE_X - PADDLE_W);
  localparam logic [9:0]  R_OUT  = 10'(H_RES - PADDLE_X);
  localparam logic [9:0]  R_BX   = 10'(H_RES - PADDLE_X - PADDLE_W - BALL_SIZE);
  localparam logic [9:0]  MID    = 10'(H_RES / 2);
  localparam logic [10:0] BS_W   = 11'(BALL_SIZE);
  localparam logic [10:0] SPD_W  = 11'(BALL_SPEED);
  localparam logic [10:0] PH_W   = 11'(PADDLE_H);
  localparam logic [10:0] STEP_W = 11'(PADDLE_STEP);
  localparam logic [10:0] PYM_W  = 11'(V_RES - PADDLE_H);
  localparam logic [10:0] R_IN_W = 11'(H_RES - PADDLE_X - PADDLE_W);
  localparam logic [10:0] H_W    = 11'(H_RES);
  localparam logic [10:0] V_W    = 11'(V_RES);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
  localparam logic [15:0] DLY    = 16'(SERVE_DELAY - 1);

  state_t      state;
  logic [9:0]  p1_y, p2_y, bx, by;
  logic        dx_neg, dy_neg;
  logic [15:0] cnt;
  logic        p1_up, p1_dn, p2_up, p2_dn, brk;

  logic [10:0] bxw, byw, p1w, p2w, xw, yw;
  assign bxw = {1'b0, bx};
  assign byw = {1'b0, by};
  assign p1w = {1'b0, p1_y};
  assign p2w = {1'b0, p2_y};
  assign xw  = {1'b0, x_pos};
  assign yw  = {1'b0, y_pos};

  logic serve_make;
  assign serve_make = done && (tasta == KEY_SERVE) && !brk;

  function automatic logic [9:0] pad_next(
    input logic [9:0] y,
    input logic       up,
    input logic       dn
  );
    logic [9:0] r;
    r = y;
    if (up && !dn)
      r = (y < STEP) ? 10'd0 : y - STEP;
    else if (dn && !up)
      r = ({1'b0, y} + STEP_W > PYM_W) ? PY_MAX : y + STEP;
    return r;
  endfunction

  function automatic logic [3:0] inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  logic p2_go_up, p2_go_dn;
`ifdef PONG_AI_EN
  logic [10:0] p2c, bc;
  always_comb begin
    p2c      = p2w + 11'(PADDLE_H / 2);
    bc       = byw + 11'(BALL_SIZE / 2);
    p2_go_up = p2c > bc + STEP_W;
    p2_go_dn = p2c + STEP_W < bc;
  end
`else
  assign p2_go_up = p2_up;
  assign p2_go_dn = p2_dn;
`endif

  logic ov1, ov2, top_hit, bot_hit;
  logic l_hit, r_hit, miss_l, miss_r;
  logic [3:0] s1_n, s2_n;
  always_comb begin
    ov1     = (byw + BS_W > p1w) && (byw < p1w + PH_W);
    ov2     = (byw + BS_W > p2w) && (byw < p2w + PH_W);
    top_hit = dy_neg && (by < SPD);
    bot_hit = !dy_neg && (byw + BS_W + SPD_W > V_W);
    l_hit   = dx_neg && (bx <= L_IN) && ov1;
    r_hit   = !dx_neg && (bxw + BS_W >= R_IN_W) && ov2;
    miss_l  = dx_neg && (bx < SPD);
    miss_r  = !dx_neg && (bxw + BS_W + SPD_W > H_W);
    s1_n    = inc(score_player_1);
    s2_n    = inc(score_player_2);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      p1_y           <= PY0;
      p2_y           <= PY0;
      bx             <= BX0;
      by             <= BY0;
      dx_neg         <= 1'b0;
      dy_neg         <= 1'b0;
      cnt            <= '0;
      score_player_1 <= '0;
      score_player_2 <= '0;
      game_over      <= 1'b0;
      winner         <= 1'b0;
      {p1_up, p1_dn, p2_up, p2_dn, brk} <= '0;
    end else begin
      // E0 prefixes pass through so the break flag survives them
      if (done) begin
        if (tasta == 8'hF0) begin
          brk <= 1'b1;
        end else if (tasta != 8'hE0) begin
          brk <= 1'b0;
          if (tasta == KEY_P1_UP) p1_up <= !brk;
          if (tasta == KEY_P1_DN) p1_dn <= !brk;
          if (tasta == KEY_P2_UP) p2_up <= !brk;
          if (tasta == KEY_P2_DN) p2_dn <= !brk;
        end
      end

      if (frame_tick && (state == SERVE || state == PLAY)) begin
        p1_y <= pad_next(p1_y, p1_up, p1_dn);
        p2_y <= pad_next(p2_y, p2_go_up, p2_go_dn);
      end

      unique case (state)
        IDLE, OVER: begin
          if (serve_make) begin
            state          <= SERVE;
            cnt            <= '0;
            bx             <= BX0;
            by             <= BY0;
            dx_neg         <= 1'b0;
            dy_neg         <= 1'b0;
            score_player_1 <= '0;
            score_player_2 <= '0;
            game_over      <= 1'b0;
            winner         <= 1'b0;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (cnt == DLY) begin
              state <= PLAY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (top_hit) begin
              by     <= '0;
              dy_neg <= 1'b0;
            end else if (bot_hit) begin
              by     <= BY_MAX;
              dy_neg <= 1'b1;
            end else if (l_hit) begin
              bx     <= L_IN;
              dx_neg <= 1'b0;
            end else if (r_hit) begin
              bx     <= R_BX;
              dx_neg <= 1'b1;
            end else if (miss_l || miss_r) begin
              // next serve heads toward whoever conceded
              bx     <= BX0;
              by     <= BY0;
              dy_neg <= 1'b0;
              dx_neg <= miss_l;
              cnt    <= '0;
              if (miss_l) score_player_2 <= s2_n;
              else        score_player_1 <= s1_n;
              if ((miss_l ? s2_n : s1_n) == WIN) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= miss_l;
              end else begin
                state <= SERVE;
              end
            end else begin
              bx <= dx_neg ? bx - SPD : bx + SPD;
              by <= dy_neg ? by - SPD : by + SPD;
            end
          end
        end
      endcase
    end
  end

  logic ball_px, pad_px, line_px;
  always_comb begin
    ball_px = (x_pos >= bx) && (xw < bxw + BS_W) &&
              (y_pos >= by) && (yw < byw + BS_W);
    pad_px  = (x_pos >= L_OUT) && (x_pos < L_IN) &&
              (y_pos >= p1_y) && (yw < p1w + PH_W);
    pad_px  = pad_px ||
              ((x_pos >= R_IN) && (x_pos < R_OUT) &&
               (y_pos >= p2_y) && (yw < p2w + PH_W));
    line_px = ((x_pos == MID - 10'd1) || (x_pos == MID)) && !y_pos[4];
  end

  always_ff @(posedge clock) begin
    if (!reset)            color <= 12'h000;
    else if (!active_zone) color <= 12'h000;
    else if (ball_px)      color <= 12'hF00;
    else if (pad_px)       color <= 12'hFFF;
    else if (line_px)      color <= 12'h888;
    else                   color <= 12'h000;
  end

endmodule
